seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter IN_W, default 10, width of the monitored input vector.
REQ-002 Parameter DEPTH, default 11, pattern-table entries; AW = $clog2(DEPTH).
REQ-003 Parameter CNT_W, default 8, width of the fail counter.
REQ-004 Parameter TIMEOUT, default 16, timeout limit in cycles; used only under CHECKER_TIMEOUT_EN.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1, clock; all registers update on its falling edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port cfg_we, input, 1, pattern-table write strobe.
REQ-009 Port cfg_addr, input, AW, table write address.
REQ-010 Port cfg_val, input, IN_W, expected value.
REQ-011 Port cfg_mask, input, IN_W, compare mask; 1 = bit checked.
REQ-012 Port cfg_len, input, AW+1, sequence length.
REQ-013 Port mode, input, 1, mismatch policy: 0 = WAIT, 1 = STRICT.
REQ-014 Port start, input, 1, begin a check run.
REQ-015 Port abort, input, 1, cancel the current run.
REQ-016 Port x, input, IN_W, monitored vector.
REQ-017 Port busy, output, 1, high while the FSM is in RUN.
REQ-018 Port idx, output, AW, current sequence position.
REQ-019 Port pass, output, 1, one-cycle pulse on sequence completion.
REQ-020 Port fail, output, 1, one-cycle pulse on sequence failure.
REQ-021 Port fail_cnt, output, CNT_W, saturating count of failures.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, PASS and FAIL; all outputs SHALL be registered (Moore).
REQ-023 A pattern entry i SHALL match when (x & mask[i]) == (val[i] & mask[i]).
REQ-024 In IDLE with start=1, the FSM SHALL latch mode and len = min(cfg_len, DEPTH), clear idx, and go to RUN; if len==0 it SHALL go directly to PASS.
REQ-025 In RUN, on a match with idx < len-1, idx SHALL increment.
REQ-026 In RUN, on a match with idx == len-1, the FSM SHALL go to PASS.
REQ-027 In RUN, on a mismatch: WAIT mode holds idx; STRICT mode goes to FAIL.
REQ-028 PASS and FAIL SHALL each last exactly one cycle and then return to IDLE; pass=1 only in PASS and fail=1 only in FAIL.
REQ-029 Entering FAIL SHALL increment fail_cnt, saturating at all-ones.
REQ-030 abort=1 in RUN SHALL return the FSM to IDLE with no pass or fail pulse; abort SHALL take priority over match or mismatch in the same cycle.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 cfg_we SHALL write the table only when the FSM is not in RUN; writes with cfg_addr >= DEPTH SHALL be ignored.
REQ-033 busy SHALL equal (state == RUN); idx SHALL hold its last value outside RUN until the next start.

Reset
REQ-034 rst=1 SHALL force, asynchronously: state IDLE, idx 0, pass 0, fail 0, busy 0, fail_cnt 0, all table val/mask 0, latched len/mode 0.
REQ-035 Reset asserted mid-run SHALL abandon the run with no pass or fail pulse.

Configuration
REQ-036 With CHECKER_TIMEOUT_EN defined, a $clog2(TIMEOUT+1)-bit counter SHALL clear on start and on each match, and increment on each RUN mismatch; reaching TIMEOUT SHALL go to FAIL (both modes).
REQ-037 Without CHECKER_TIMEOUT_EN, no timeout counter SHALL exist and WAIT mode SHALL wait indefinitely.

Structure
REQ-038 Package seq_checker_pkg SHALL hold the state enum and the default parameter constants.
REQ-039 The pattern table (val/mask register array plus match compare) SHALL be the sub-module seq_checker_ptab.

Verification
REQ-040 Load len=3 patterns 0x001/0x002/0x004, full masks; start; drive x = 1, 2, 4 -> pass pulse in the cycle after x=4, busy drops, fail_cnt=0.
REQ-041 STRICT mode, same table, x = 1, 3 -> fail pulse, fail_cnt=1, state IDLE.
REQ-042 WAIT mode, x = 1, 7, 7, 2, 4 -> idx holds at 1 during the 7s, then pass.
REQ-043 abort during RUN with x matching the last entry in the same cycle -> no pass/fail pulse, busy=0.
REQ-044 cfg_len=0 with start -> pass pulse one cycle later; cfg_len=15 clamps to 11.
REQ-045 With CHECKER_TIMEOUT_EN and TIMEOUT=16, WAIT mode with x held at a non-matching value -> fail after 16 mismatch cycles; also run 256 failures -> fail_cnt saturates at 0xFF.

Source files
------------

// File: rtl/seq_checker_pkg.sv
// Shared types and default parameters for the sequence checker.
// The optional timeout is enabled with the CHECKER_TIMEOUT_EN macro.
package seq_checker_pkg;

  localparam int DEF_IN_W    = 10;
  localparam int DEF_DEPTH   = 11;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic {
    MODE_WAIT   = 1'b0,
    MODE_STRICT = 1'b1
  } mode_e;

endpackage

// File: rtl/seq_checker_ptab.sv
// Pattern table: per-entry expected value and compare mask, plus the masked
// match of the monitored vector against the entry selected by rd_idx.
module seq_checker_ptab
  import seq_checker_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [IN_W-1:0] val,
  input  logic [IN_W-1:0] mask,
  input  logic [AW-1:0]   rd_idx,
  input  logic [IN_W-1:0] x,
  output logic            match
);

  logic [IN_W-1:0] r_val  [DEPTH];
  logic [IN_W-1:0] r_mask [DEPTH];
  logic            w_rd_ok;

  // NOTE: the table is reset explicitly because a zero mask (match-anything) after reset is observable behaviour.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_val[i]  <= '0;
        r_mask[i] <= '0;
      end
    end else if (we && (int'(addr) < DEPTH)) begin
      r_val[addr]  <= val;
      r_mask[addr] <= mask;
    end
  end

  assign w_rd_ok = (int'(rd_idx) < DEPTH);
  assign match   = w_rd_ok &&
                   ((x & r_mask[rd_idx]) == (r_val[rd_idx] & r_mask[rd_idx]));

endmodule

// File: rtl/seq_checker.sv
// Sequence checker: steps through a programmed pattern table as x matches.
// Define CHECKER_TIMEOUT_EN to fail a run after TIMEOUT consecutive mismatches.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [IN_W-1:0]  cfg_val,
  input  logic [IN_W-1:0]  cfg_mask,
  input  logic [LW-1:0]    cfg_len,
  input  logic             mode,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  x,
  output logic             busy,
  output logic [AW-1:0]    idx,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt
);

  state_e           r_state;
  mode_e            r_mode;
  logic [LW-1:0]    r_len;
  logic [AW-1:0]    r_idx;
  logic             r_busy;
  logic             r_pass;
  logic             r_fail;
  logic [CNT_W-1:0] r_fail_cnt;

  logic             w_match;
  logic             w_timeout;
  logic [LW-1:0]    w_len;
  logic [LW-1:0]    w_last;

  seq_checker_ptab #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptab (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we && (r_state != ST_RUN)),
    .addr   (cfg_addr),
    .val    (cfg_val),
    .mask   (cfg_mask),
    .rd_idx (r_idx),
    .x      (x),
    .match  (w_match)
  );

  assign w_len  = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
  assign w_last = r_len - 1'b1;

`ifdef CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  // The mismatch that would bring the count to TIMEOUT is the one that fails.
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_WAIT;
      r_len      <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
`ifdef CHECKER_TIMEOUT_EN
      r_to_cnt   <= '0;
`endif
    end else begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= mode_e'(mode);
            r_len  <= w_len;
            r_idx  <= '0;
`ifdef CHECKER_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            if (w_len == '0) begin
              r_state <= ST_PASS;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_match) begin
`ifdef CHECKER_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            if ({1'b0, r_idx} == w_last) begin
              r_state <= ST_PASS;
              r_busy  <= 1'b0;
              r_pass  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if ((r_mode == MODE_STRICT) || w_timeout) begin
            r_state <= ST_FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
          end else begin
`ifdef CHECKER_TIMEOUT_EN
            r_to_cnt <= r_to_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign idx      = r_idx;
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the checker.
module tb_seq_checker;

  localparam int IN_W    = 10;
  localparam int DEPTH   = 11;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int FULL    = (1 << IN_W) - 1;
`ifdef CHECKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [IN_W-1:0]  cfg_val;
  logic [IN_W-1:0]  cfg_mask;
  logic [AW:0]      cfg_len;
  logic             mode;
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  x;
  logic             busy;
  logic [AW-1:0]    idx;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] fail_cnt;

  seq_checker #(
    .IN_W    (IN_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_val  (cfg_val),
    .cfg_mask (cfg_mask),
    .cfg_len  (cfg_len),
    .mode     (mode),
    .start    (start),
    .abort    (abort),
    .x        (x),
    .busy     (busy),
    .idx      (idx),
    .pass     (pass),
    .fail     (fail),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 running, 2 pass pulse, 3 fail pulse.
  int tv [DEPTH];
  int tm [DEPTH];
  int m_phase, m_idx, m_len, m_fails, m_miss;
  bit m_strict;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tv[i] = 0;
      tm[i] = 0;
    end
    m_phase = 0; m_idx = 0; m_len = 0; m_fails = 0; m_miss = 0; m_strict = 0;
  endtask

  task automatic model_step();
    int  xin;
    bit  running;
    xin     = int'(x);
    running = (m_phase == 1);
    case (m_phase)
      0: if (start) begin
        m_len    = (int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
        m_strict = mode;
        m_idx    = 0;
        m_miss   = 0;
        m_phase  = (m_len == 0) ? 2 : 1;
      end
      1: begin
        if (abort) m_phase = 0;
        else if (((xin ^ tv[m_idx]) & tm[m_idx]) == 0) begin
          m_miss = 0;
          if (m_idx == m_len - 1) m_phase = 2;
          else m_idx++;
        end else begin
          m_miss++;
          if (m_strict || (TO_EN && m_miss >= TIMEOUT)) begin
            m_phase = 3;
            m_fails++;
          end
        end
      end
      default: m_phase = 0;
    endcase
    if (cfg_we && !running && int'(cfg_addr) < DEPTH) begin
      tv[cfg_addr] = int'(cfg_val);
      tm[cfg_addr] = int'(cfg_mask);
    end
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      check("busy", busy, int'(m_phase == 1));
      check("idx", idx, m_idx);
      check("pass", pass, int'(m_phase == 2));
      check("fail", fail, int'(m_phase == 3));
      check("fail_cnt", fail_cnt, (m_fails > 255) ? 255 : m_fails);
    end
  end

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic cfg_write(input int a, input int v, input int m);
    idle_inputs();
    cfg_we   = 1'b1;
    cfg_addr = a[AW-1:0];
    cfg_val  = v[IN_W-1:0];
    cfg_mask = m[IN_W-1:0];
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int len, input bit md);
    idle_inputs();
    start   = 1'b1;
    cfg_len = len[AW:0];
    mode    = md;
    step();
    start = 1'b0;
  endtask

  task automatic run_x(input int v);
    idle_inputs();
    x = v[IN_W-1:0];
    step();
  endtask

  task automatic load_124();
    cfg_write(0, 1, FULL);
    cfg_write(1, 2, FULL);
    cfg_write(2, 4, FULL);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    idle_inputs();
    cfg_addr = '0; cfg_val = '0; cfg_mask = '0; cfg_len = '0; mode = 1'b0; x = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_cnt", fail_cnt, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Basic pass: 1, 2, 4
    load_124();
    do_start(3, 1'b0);
    check("run_busy", busy, 1);
    run_x(1); run_x(2); run_x(4);
    check("p040_pass", pass, 1);
    check("p040_busy", busy, 0);
    check("p040_cnt", fail_cnt, 0);
    run_x(0);

    // STRICT failure
    do_start(3, 1'b1);
    run_x(1); run_x(3);
    check("p041_fail", fail, 1);
    check("p041_cnt", fail_cnt, 1);
    run_x(0);
    check("p041_idle", busy, 0);

    // WAIT mode holds idx on mismatches
    do_start(3, 1'b0);
    run_x(1); run_x(7);
    check("p042_idx_a", idx, 1);
    run_x(7);
    check("p042_idx_b", idx, 1);
    check("p042_busy", busy, 1);
    run_x(2); run_x(4);
    check("p042_pass", pass, 1);
    run_x(0);

    // Abort wins over a matching last entry
    do_start(3, 1'b0);
    run_x(1); run_x(2);
    idle_inputs();
    abort = 1'b1;
    x     = 10'd4;
    step();
    abort = 1'b0;
    check("p043_pass", pass, 0);
    check("p043_fail", fail, 0);
    check("p043_busy", busy, 0);

    // Zero length passes immediately
    do_start(0, 1'b0);
    check("p044_zero", pass, 1);
    run_x(0);

    // Reset mid-run abandons the run and clears the table
    do_start(3, 1'b0);
    run_x(1);
    rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_idx", idx, 0);
    check("mrst_cnt", fail_cnt, 0);
    model_reset();
    idle_inputs();
    rst = 1'b0;
    step();

    // Length 15 clamps to DEPTH; zero masks match anything
    do_start(15, 1'b1);
    repeat (10) run_x(int'($urandom_range(0, FULL)));
    check("clamp_idx", idx, 10);
    check("clamp_busy", busy, 1);
    run_x(int'($urandom_range(0, FULL)));
    check("clamp_pass", pass, 1);
    run_x(0);

    cfg_write(0, 1, FULL);
`ifdef CHECKER_TIMEOUT_EN
    do_start(1, 1'b0);
    repeat (TIMEOUT - 1) run_x(0);
    check("to_busy", busy, 1);
    check("to_nofail", fail, 0);
    run_x(0);
    check("to_fail", fail, 1);
    run_x(0);
`endif

    // Saturation of the failure counter
    for (int i = 0; i < 260; i++) begin
      do_start(1, 1'b1);
      run_x(0);
      run_x(0);
    end
    check("sat_cnt", fail_cnt, 255);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      idle_inputs();
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_addr = AW'($urandom_range(0, (1 << AW) - 1));
      cfg_val  = IN_W'($urandom_range(0, FULL));
      cfg_mask = ($urandom_range(0, 3) == 0) ? IN_W'($urandom_range(0, FULL)) : IN_W'(FULL);
      cfg_len  = (AW + 1)'($urandom_range(0, (2 << AW) - 1));
      mode     = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 15) == 0);
      r        = int'($urandom_range(0, 3));
      if (m_phase == 1 && r != 0) x = IN_W'(tv[m_idx]);
      else x = IN_W'($urandom_range(0, FULL));
      step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
